// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter slice.
package sdram_arb_pkg;

    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B, OWN_R} arb_owner_t;
    typedef enum logic {ST_IDLE, ST_WAIT} arb_state_t;

    localparam int AGE_W = 8;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    function automatic logic [1:0] lane_ds(input logic addr0);
        return addr0 ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [7:0] lane_rd(input logic addr0, input logic [15:0] word);
        return addr0 ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Single-outstanding command/completion channel towards the SDRAM controller.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 22
);
    logic              mem_req;
    logic [ADDR_W-2:0] mem_addr;
    logic              mem_we;
    logic [1:0]        mem_ds;
    logic [15:0]       mem_din;
    logic              mem_ack;
    logic [15:0]       mem_dout;

    modport master (
        output mem_req, mem_addr, mem_we, mem_ds, mem_din,
        input  mem_ack, mem_dout
    );

    modport slave (
        input  mem_req, mem_addr, mem_we, mem_ds, mem_din,
        output mem_ack, mem_dout
    );
endinterface

// File: rtl/sdram_arb_strobe_port.sv
// Strobe-port capture unit: latches one 8-bit access, packs it onto the 16-bit
// word channel and returns the selected byte lane on completion.
module sdram_arb_strobe_port
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = 22
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd,
    input  logic              wr,
    input  logic [7:0]        din,
    input  logic              done,
    input  logic [15:0]       mem_dout,
    output logic              pending,
    output logic [ADDR_W-2:0] cmd_addr,
    output logic              cmd_we,
    output logic [1:0]        cmd_ds,
    output logic [15:0]       cmd_din,
    output logic [7:0]        dout,
    output logic              valid,
    output logic              busy,
    output logic              overrun
);

    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [7:0]        din_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            din_q   <= '0;
            dout    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            valid <= done;
            if (done) begin
                pending <= 1'b0;
                if (!we_q) dout <= lane_rd(addr_q[0], mem_dout);
            end
            // pending is still set in the ack cycle, so a strobe there is an overrun
            if (rd || wr) begin
                if (pending) begin
                    overrun <= 1'b1;
                end else begin
                    pending <= 1'b1;
                    addr_q  <= addr;
                    we_q    <= wr;
                    din_q   <= din;
                end
            end
        end
    end

    assign busy     = pending;
    assign cmd_addr = addr_q[ADDR_W-1:1];
    assign cmd_we   = we_q;
    assign cmd_ds   = lane_ds(addr_q[0]);
    assign cmd_din  = {din_q, din_q};

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one single-outstanding SDRAM request channel between two 8-bit strobe
// ports (A, B) and a 16-bit toggle-handshake port (R), with R starvation control.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W      = 22,
    parameter int RV_MAX_WAIT = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [ADDR_W-1:0]    a_addr,
    input  logic                 a_rd,
    input  logic                 a_wr,
    input  logic [7:0]           a_din,
    output logic [7:0]           a_dout,
    output logic                 a_valid,
    output logic                 a_busy,
    input  logic [ADDR_W-1:0]    b_addr,
    input  logic                 b_rd,
    input  logic                 b_wr,
    input  logic [7:0]           b_din,
    output logic [7:0]           b_dout,
    output logic                 b_valid,
    output logic                 b_busy,
    input  logic [ADDR_W-2:0]    rv_addr,
    input  logic                 rv_we,
    input  logic [1:0]           rv_ds,
    input  logic [15:0]          rv_din,
    input  logic                 rv_req,
    output logic                 rv_req_ack,
    output logic [15:0]          rv_dout,
    sdram_port_arbiter_if.master mem,
    output logic                 overrun
);

    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(RV_MAX_WAIT);

    arb_state_t        state, state_nxt;
    arb_owner_t        owner, grant;
    logic              ack_seen, a_done, b_done;
    logic              a_pend, b_pend, a_ovr, b_ovr;
    logic [ADDR_W-2:0] a_cmd_addr, b_cmd_addr, cmd_addr;
    logic              a_cmd_we, b_cmd_we, cmd_we;
    logic [1:0]        a_cmd_ds, b_cmd_ds, cmd_ds;
    logic [15:0]       a_cmd_din, b_cmd_din, cmd_din;
    logic              rv_req_q, rv_pend, rv_first;
    logic [AGE_W-1:0]  rv_age;

    assign ack_seen = (state == ST_WAIT) && mem.mem_ack;
    assign a_done   = ack_seen && (owner == OWN_A);
    assign b_done   = ack_seen && (owner == OWN_B);
    // rv_req is registered once so R becomes visible on the same edge as a strobe capture
    assign rv_pend  = rv_req_q ^ rv_req_ack;
    assign rv_first = rv_age >= AGE_LIMIT;
    assign overrun  = a_ovr | b_ovr;

    sdram_arb_strobe_port #(.ADDR_W(ADDR_W)) u_port_a (
        .clk(clk), .resetn(resetn),
        .addr(a_addr), .rd(a_rd), .wr(a_wr), .din(a_din),
        .done(a_done), .mem_dout(mem.mem_dout),
        .pending(a_pend), .cmd_addr(a_cmd_addr), .cmd_we(a_cmd_we),
        .cmd_ds(a_cmd_ds), .cmd_din(a_cmd_din),
        .dout(a_dout), .valid(a_valid), .busy(a_busy), .overrun(a_ovr)
    );

    sdram_arb_strobe_port #(.ADDR_W(ADDR_W)) u_port_b (
        .clk(clk), .resetn(resetn),
        .addr(b_addr), .rd(b_rd), .wr(b_wr), .din(b_din),
        .done(b_done), .mem_dout(mem.mem_dout),
        .pending(b_pend), .cmd_addr(b_cmd_addr), .cmd_we(b_cmd_we),
        .cmd_ds(b_cmd_ds), .cmd_din(b_cmd_din),
        .dout(b_dout), .valid(b_valid), .busy(b_busy), .overrun(b_ovr)
    );

    always_comb begin
        state_nxt = state;
        grant     = OWN_NONE;
        unique case (state)
            ST_IDLE: begin
                if (a_pend)                  grant = OWN_A;
                else if (rv_pend && rv_first) grant = OWN_R;
                else if (b_pend)             grant = OWN_B;
                else if (rv_pend)            grant = OWN_R;
                if (grant != OWN_NONE) state_nxt = ST_WAIT;
            end
            ST_WAIT: if (mem.mem_ack) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_addr = a_cmd_addr;
        cmd_we   = a_cmd_we;
        cmd_ds   = a_cmd_ds;
        cmd_din  = a_cmd_din;
        unique case (grant)
            OWN_B: begin
                cmd_addr = b_cmd_addr;
                cmd_we   = b_cmd_we;
                cmd_ds   = b_cmd_ds;
                cmd_din  = b_cmd_din;
            end
            OWN_R: begin
                cmd_addr = rv_addr;
                cmd_we   = rv_we;
                cmd_ds   = rv_ds;
                cmd_din  = rv_din;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner        <= OWN_NONE;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            mem.mem_we   <= 1'b0;
            mem.mem_ds   <= '0;
            mem.mem_din  <= '0;
            rv_req_q     <= 1'b0;
            rv_req_ack   <= 1'b0;
            rv_dout      <= '0;
            rv_age       <= '0;
        end else begin
            rv_req_q    <= rv_req;
            mem.mem_req <= (grant != OWN_NONE);
            if (grant != OWN_NONE) begin
                owner        <= grant;
                mem.mem_addr <= cmd_addr;
                mem.mem_we   <= cmd_we;
                mem.mem_ds   <= cmd_ds;
                mem.mem_din  <= cmd_din;
            end
            if (ack_seen) begin
                owner <= OWN_NONE;
                if (owner == OWN_R) begin
                    rv_req_ack <= rv_req_q;
                    if (!mem.mem_we) rv_dout <= mem.mem_dout;
                end
            end
            if (!rv_pend || grant == OWN_R)
                rv_age <= '0;
            else if (grant == OWN_B && rv_age != AGE_MAX)
                rv_age <= rv_age + 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter with a fixed-latency memory model.
module tb_sdram_port_arbiter;
    import sdram_arb_pkg::*;

    localparam int ADDR_W = 22;
    localparam int AW     = ADDR_W - 1;
    localparam int LAT    = 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [1:0]    ds;
        logic [15:0]   din;
    } cmd_t;
    typedef struct packed { logic rd; logic [7:0]  d; } cpl8_t;
    typedef struct packed { logic rd; logic [15:0] d; } cpl16_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
    logic a_rd = 1'b0, a_wr = 1'b0, b_rd = 1'b0, b_wr = 1'b0;
    logic [7:0] a_din = '0, b_din = '0;
    logic [7:0] a_dout, b_dout;
    logic a_valid, a_busy, b_valid, b_busy;
    logic [AW-1:0] rv_addr = '0;
    logic rv_we = 1'b0;
    logic [1:0] rv_ds = '0;
    logic [15:0] rv_din = '0;
    logic rv_req = 1'b0;
    logic rv_req_ack;
    logic [15:0] rv_dout;
    logic overrun;

    logic auto_ack = 1'b1, manual_ack = 1'b0;
    logic [15:0] manual_dout = '0;

    arb_owner_t grant_q[$];
    cmd_t a_cmd_q[$], b_cmd_q[$], r_cmd_q[$];
    cpl8_t a_cpl_q[$], b_cpl_q[$];
    cpl16_t r_cpl_q[$];
    logic [7:0] a_dout_m = '0, b_dout_m = '0;
    logic [15:0] rv_dout_m = '0;

    int checks = 0;
    int failures = 0;

    sdram_port_arbiter_if #(.ADDR_W(ADDR_W)) mif();

    sdram_port_arbiter #(.ADDR_W(ADDR_W), .RV_MAX_WAIT(8)) dut (
        .clk(clk), .resetn(resetn),
        .a_addr(a_addr), .a_rd(a_rd), .a_wr(a_wr), .a_din(a_din),
        .a_dout(a_dout), .a_valid(a_valid), .a_busy(a_busy),
        .b_addr(b_addr), .b_rd(b_rd), .b_wr(b_wr), .b_din(b_din),
        .b_dout(b_dout), .b_valid(b_valid), .b_busy(b_busy),
        .rv_addr(rv_addr), .rv_we(rv_we), .rv_ds(rv_ds), .rv_din(rv_din),
        .rv_req(rv_req), .rv_req_ack(rv_req_ack), .rv_dout(rv_dout),
        .mem(mif), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mdata(input logic [AW-1:0] w);
        return 16'hBEEE + w[15:0];
    endfunction

    task automatic tick();
        @(negedge clk);
        a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
    endtask

    task automatic strobe(input arb_owner_t p, input logic rd, input logic wr,
                          input logic [ADDR_W-1:0] addr, input logic [7:0] din);
        cmd_t c;
        cpl8_t e;
        logic [15:0] w;
        c.addr = addr[ADDR_W-1:1];
        c.we   = wr;
        c.ds   = addr[0] ? 2'b10 : 2'b01;
        c.din  = {din, din};
        w      = mdata(addr[ADDR_W-1:1]);
        e.rd   = !wr;
        e.d    = addr[0] ? w[15:8] : w[7:0];
        if (p == OWN_A) begin
            a_rd = rd; a_wr = wr; a_addr = addr; a_din = din;
            a_cmd_q.push_back(c); a_cpl_q.push_back(e);
        end else begin
            b_rd = rd; b_wr = wr; b_addr = addr; b_din = din;
            b_cmd_q.push_back(c); b_cpl_q.push_back(e);
        end
    endtask

    task automatic r_issue(input logic we, input logic [AW-1:0] addr,
                           input logic [1:0] ds, input logic [15:0] din);
        cmd_t c;
        cpl16_t e;
        rv_addr = addr; rv_we = we; rv_ds = ds; rv_din = din;
        rv_req  = ~rv_req;
        c.addr = addr; c.we = we; c.ds = ds; c.din = din;
        e.rd = !we; e.d = mdata(addr);
        r_cmd_q.push_back(c); r_cpl_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((a_busy || b_busy || rv_req != rv_req_ack || grant_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        check(tag, 64'(n < 200), 64'(1));
        tick();
        tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ports"}, 64'({a_dout, a_valid, a_busy, b_dout, b_valid, b_busy,
                                    rv_req_ack, rv_dout, overrun}), 64'(0));
        check({tag, "_mem"}, 64'({mif.mem_req, mif.mem_addr, mif.mem_we, mif.mem_ds,
                                  mif.mem_din}), 64'(0));
    endtask

    // memory model: ack LAT+1 cycles after a request is seen, data derived from the address
    initial begin : mem_model
        int cd = -1;
        logic [AW-1:0] pa = '0;
        mif.mem_ack  = 1'b0;
        mif.mem_dout = '0;
        forever begin
            @(negedge clk);
            mif.mem_ack  = manual_ack;
            mif.mem_dout = manual_ack ? manual_dout : 16'($urandom);
            if (!resetn) begin
                cd = -1;
            end else if (cd == 0) begin
                mif.mem_ack  = 1'b1;
                mif.mem_dout = mdata(pa);
                cd = -1;
            end else if (cd > 0) begin
                cd--;
            end
            if (resetn && auto_ack && mif.mem_req) begin
                pa = mif.mem_addr;
                cd = LAT;
            end
        end
    end

    initial begin : monitor
        logic prev_req = 1'b0, prev_av = 1'b0, prev_bv = 1'b0, prev_ack = 1'b0;
        arb_owner_t own;
        cmd_t got_c;
        cpl8_t e8;
        cpl16_t e16;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_req = 1'b0; prev_av = 1'b0; prev_bv = 1'b0; prev_ack = rv_req_ack;
            end else begin
                if (prev_req) check("mem_req_pulse", 64'(mif.mem_req), 64'(0));
                if (mif.mem_req) begin
                    got_c = {mif.mem_addr, mif.mem_we, mif.mem_ds, mif.mem_din};
                    check("grant_expected", 64'(grant_q.size() != 0), 64'(1));
                    if (grant_q.size() != 0) begin
                        own = grant_q.pop_front();
                        case (own)
                            OWN_A: begin
                                check("cmd_a_avail", 64'(a_cmd_q.size() != 0), 64'(1));
                                if (a_cmd_q.size() != 0) check("cmd_a", 64'(got_c), 64'(a_cmd_q.pop_front()));
                            end
                            OWN_B: begin
                                check("cmd_b_avail", 64'(b_cmd_q.size() != 0), 64'(1));
                                if (b_cmd_q.size() != 0) check("cmd_b", 64'(got_c), 64'(b_cmd_q.pop_front()));
                            end
                            default: begin
                                check("cmd_r_avail", 64'(r_cmd_q.size() != 0), 64'(1));
                                if (r_cmd_q.size() != 0) check("cmd_r", 64'(got_c), 64'(r_cmd_q.pop_front()));
                            end
                        endcase
                    end
                end
                if (prev_av) check("a_valid_pulse", 64'(a_valid), 64'(0));
                if (a_valid) begin
                    check("a_cpl_expected", 64'(a_cpl_q.size() != 0), 64'(1));
                    if (a_cpl_q.size() != 0) begin
                        e8 = a_cpl_q.pop_front();
                        if (e8.rd) a_dout_m = e8.d;
                        check("a_dout", 64'(a_dout), 64'(a_dout_m));
                    end
                end
                if (prev_bv) check("b_valid_pulse", 64'(b_valid), 64'(0));
                if (b_valid) begin
                    check("b_cpl_expected", 64'(b_cpl_q.size() != 0), 64'(1));
                    if (b_cpl_q.size() != 0) begin
                        e8 = b_cpl_q.pop_front();
                        if (e8.rd) b_dout_m = e8.d;
                        check("b_dout", 64'(b_dout), 64'(b_dout_m));
                    end
                end
                if (rv_req_ack != prev_ack) begin
                    check("rv_ack", 64'(rv_req_ack), 64'(rv_req));
                    check("r_cpl_expected", 64'(r_cpl_q.size() != 0), 64'(1));
                    if (r_cpl_q.size() != 0) begin
                        e16 = r_cpl_q.pop_front();
                        if (e16.rd) rv_dout_m = e16.d;
                        check("rv_dout", 64'(rv_dout), 64'(rv_dout_m));
                    end
                end
                prev_req = mif.mem_req;
                prev_av  = a_valid;
                prev_bv  = b_valid;
                prev_ack = rv_req_ack;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int na, nb, n;
        repeat (2) @(negedge clk);
        check_zero("reset");
        resetn = 1'b1;
        tick();

        // single A read of an odd byte address
        tick(); strobe(OWN_A, 1'b1, 1'b0, 22'h000003, 8'h00); grant_q.push_back(OWN_A);
        drain("t1_read");

        // A write plus B rd+wr together: write wins on B
        tick();
        strobe(OWN_A, 1'b0, 1'b1, 22'h000000, 8'h77);
        strobe(OWN_B, 1'b1, 1'b1, 22'h000005, 8'h33);
        grant_q.push_back(OWN_A); grant_q.push_back(OWN_B);
        drain("t1_write");

        // all three ports in one cycle
        tick();
        strobe(OWN_A, 1'b1, 1'b0, 22'h000100, 8'h00);
        strobe(OWN_B, 1'b0, 1'b1, 22'h000010, 8'h5A);
        r_issue(1'b0, 21'h002222, 2'b11, 16'h0000);
        grant_q.push_back(OWN_A); grant_q.push_back(OWN_B); grant_q.push_back(OWN_R);
        drain("t2_all");

        // A and B alternate while R waits; R overtakes B after 8 lost B grants
        repeat (8) begin grant_q.push_back(OWN_A); grant_q.push_back(OWN_B); end
        grant_q.push_back(OWN_A); grant_q.push_back(OWN_R);
        grant_q.push_back(OWN_A); grant_q.push_back(OWN_B);
        tick();
        strobe(OWN_A, 1'b1, 1'b0, 22'h001000, 8'h00);
        strobe(OWN_B, 1'b1, 1'b0, 22'h002001, 8'h00);
        r_issue(1'b0, 21'h003333, 2'b11, 16'h0000);
        na = 1; nb = 1; n = 0;
        while ((na < 10 || nb < 9) && n < 600) begin
            tick();
            n++;
            if (!a_busy && na < 10) begin
                strobe(OWN_A, 1'b1, 1'b0, 22'h001000 + 22'(2 * na), 8'h00);
                na++;
            end
            if (!b_busy && nb < 9) begin
                strobe(OWN_B, 1'b1, 1'b0, 22'h002001 + 22'(2 * nb), 8'h00);
                nb++;
            end
        end
        check("t3_budget", 64'(n < 600), 64'(1));
        drain("t3_age");
        check("t3_no_overrun", 64'(overrun), 64'(0));

        // age has cleared: B again beats a freshly pending R
        tick();
        strobe(OWN_B, 1'b1, 1'b0, 22'h000201, 8'h00);
        r_issue(1'b0, 21'h000444, 2'b11, 16'h0000);
        grant_q.push_back(OWN_B); grant_q.push_back(OWN_R);
        drain("t3_age_clear");

        // R write passes fields through, rv_dout holds
        tick();
        r_issue(1'b1, 21'h000ABC, 2'b01, 16'h1234);
        grant_q.push_back(OWN_R);
        drain("t6_rwrite");

        // B strobe while busy is dropped and flagged
        tick(); strobe(OWN_B, 1'b1, 1'b0, 22'h000100, 8'h00); grant_q.push_back(OWN_B);
        tick();
        check("t4_ovr_before", 64'(overrun), 64'(0));
        check("t4_b_busy", 64'(b_busy), 64'(1));
        b_rd = 1'b1; b_addr = 22'h000200;
        tick(); tick();
        check("t4_overrun", 64'(overrun), 64'(1));
        drain("t4_drop");
        check("t4_overrun_sticky", 64'(overrun), 64'(1));

        // reset while B is in flight, then a late ack
        auto_ack = 1'b0;
        tick(); strobe(OWN_B, 1'b1, 1'b0, 22'h000044, 8'h00); grant_q.push_back(OWN_B);
        repeat (4) tick();
        check("t5_b_busy", 64'(b_busy), 64'(1));
        check("t5_granted", 64'(grant_q.size()), 64'(0));
        #2 resetn = 1'b0;
        #1 check_zero("t5_async");
        rv_req = 1'b0;
        a_cmd_q.delete(); b_cmd_q.delete(); r_cmd_q.delete(); grant_q.delete();
        a_cpl_q.delete(); b_cpl_q.delete(); r_cpl_q.delete();
        a_dout_m = '0; b_dout_m = '0; rv_dout_m = '0;
        repeat (2) tick();
        resetn = 1'b1;
        @(negedge clk); #2 manual_dout = 16'hCAFE; manual_ack = 1'b1;
        @(negedge clk); #2 manual_ack = 1'b0;
        repeat (3) begin
            tick();
            check("t5_no_b_valid", 64'(b_valid), 64'(0));
            check("t5_no_req", 64'(mif.mem_req), 64'(0));
        end
        auto_ack = 1'b1;

        // normal operation after reset
        tick(); strobe(OWN_A, 1'b1, 1'b0, 22'h000003, 8'h00); grant_q.push_back(OWN_A);
        drain("t5_after");
        check("end_queues", 64'(a_cmd_q.size() + b_cmd_q.size() + r_cmd_q.size()
                                + a_cpl_q.size() + b_cpl_q.size() + r_cpl_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
